elevator_ctrl_n: RTL and testbench
==================================

Name: elevator_ctrl_n

Overview:
Parametrised next-generation elevator car controller for FLOORS floors.
- Absorbs the request register, the move timer and the door timer, which were external to the 4-floor controller.
- Adds direction persistence (collective control) and door-hold/re-open.
- Sits between the request-capture logic (buttons) and the display/door/motor drivers; clocked by the 32 Hz system tick.

Parameters:
FLOORS, 4, number of floors; minimum 2; position is one-hot of this width.
MOVE_TICKS, 32, clk cycles spent in MOVE per floor transition; minimum 1.
DOOR_TICKS, 64, clk cycles the door stays open with no re-open; minimum 1.

Ports:
clk  in  1  system clock (32 Hz tick domain).
rst  in  1  synchronous reset, active-high.
switch  in  1  master enable; 0 forces OFF.
req_in  in  FLOORS  request pulses, bit i = floor i; OR-ed into pending.
door_hold  in  1  open-door button; restarts the door timer while in DOOR.
state  out  2  0=OFF, 1=PAUSE, 2=MOVE, 3=DOOR.
position  out  FLOORS  one-hot current floor.
floor_idx  out  $clog2(FLOORS)  binary index of position.
ud_mode  out  2  00 idle, 01 up, 10 down.
door_open  out  1  high exactly while state==DOOR.
moving  out  1  high exactly while state==MOVE.
pending  out  FLOORS  registered outstanding requests.

Behaviour:
Clocking and reset:
- All flops update on posedge clk.
- rst or switch==0 (rst has priority; both are sync and both apply from any state, including mid-MOVE or mid-DOOR) sets: state=OFF, position=1 (floor 0), floor_idx=0, ud_mode=00, pending=0, timers=0, door_open=0, moving=0.
- req_in is ignored while rst or switch==0.

Request register:
- pending_next = (pending | req_in) & ~clr.
- clr = position when the next state is DOOR, or when state is DOOR; otherwise 0.
- A request for the current floor is never left pending across a door cycle.

Need and direction (combinational, from pending):
- up_need = |(pending & mask of floors above position); down_need likewise for floors below.
- ud_mode is registered every cycle outside OFF:
  - If pending==0: 00.
  - Else if ud_mode==01 and up_need: 01. Else if ud_mode==10 and down_need: 10.
  - Else if up_need: 01. Else if down_need: 10. Else hold.
- This replaces the old up-first priority with a direction that persists while work remains in that direction.

State machine:
- OFF: if switch==1 (and not rst), go to PAUSE next cycle.
- PAUSE:
  - If (pending|req_in) & position is nonzero: go to DOOR, door_cnt=0. door_open is high the very next cycle (1-cycle latency).
  - Else if up_need|down_need: go to MOVE, move_cnt=0, and latch move_dir from the ud_mode_next value.
  - Else stay in PAUSE.
- DOOR:
  - door_cnt increments each cycle.
  - door_hold==1, or req_in hitting the current floor, reloads door_cnt=0.
  - When door_cnt==DOOR_TICKS-1 with no reload: go to PAUSE.
  - Door time is therefore DOOR_TICKS cycles minimum.
- MOVE:
  - move_cnt increments each cycle.
  - When move_cnt==MOVE_TICKS-1: position shifts by one floor (left if move_dir==up, right if down), floor_idx tracks it, state goes to PAUSE.
  - move_dir is frozen for the whole transition; ud_mode changes do not affect it.
  - Requests for floors being passed are latched only; the stop decision is made in PAUSE.
- Per-floor travel = 1 PAUSE cycle + MOVE_TICKS cycles.

Boundaries:
- Position saturates: no left shift at the top floor, no right shift at floor 0. This is defensive only; it is unreachable when need is correct.
- Simultaneous clr and req_in on the same bit: clr wins while in DOOR; the request is considered serviced.
- Any non-one-hot position is an illegal state; assertion only, no recovery logic.

Decomposition:
- Package elevator_pkg: state encodings (ST_OFF, ST_PAUSE, ST_MOVE, ST_DOOR), ud_mode encodings (UD_IDLE, UD_UP, UD_DOWN).
- One sub-module, elevator_timer: parametrised up-counter with clear/reload, enable and done at TICKS-1. Instantiated twice, once for the move timer and once for the door timer.
- Direction/need logic stays inline.

Test Plan (FLOORS=4, MOVE_TICKS=4, DOOR_TICKS=3 unless noted):
1. Reset and start: rst=1 for 2 cycles -> state=0, position=0001, pending=0000. Then switch=1 -> state=1 after 1 cycle.
2. Simple up: in PAUSE at floor 0, pulse req_in=0100.
   - ud_mode=01, moving=1.
   - position=0010 after 5 cycles; position=0100 after 10 cycles.
   - door_open=1 for exactly 3 cycles; pending=0000.
   - Then ud_mode=00, state=1.
3. Direction persistence: moving up from floor 0 to floor 1, pending=1001 -> car continues to 1000 first (door cycle), then returns to 0001.
4. Door hold and re-open: door_hold=1 on the 2nd DOOR cycle -> door_open lasts 2+3=5 cycles. req_in for the current floor during DOOR behaves the same way.
5. Abort: switch=0 mid-MOVE at position 0100 -> next cycle state=0, position=0001, pending=0000, moving=0. Same result with rst=1.
6. Width scaling: FLOORS=8, MOVE_TICKS=2, req_in=10000000 from floor 0 -> position=10000000 after 21 cycles, floor_idx=7, door_open next cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator car controller: FSM states and travel direction.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_MOVE  = 2'd2,
        ST_DOOR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        UD_IDLE = 2'b00,
        UD_UP   = 2'b01,
        UD_DOWN = 2'b10
    } ud_t;

endpackage

// File: rtl/elevator_timer.sv
// Up-counter that raises done on count TICKS-1; clr returns it to zero, en advances it.
module elevator_timer #(
    parameter int TICKS = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/elevator_ctrl_n.sv
// Collective-control elevator car controller: request register, direction persistence,
// move/door timing and door re-open for FLOORS floors.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int FLOORS     = 4,
    parameter int MOVE_TICKS = 32,
    parameter int DOOR_TICKS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      switch,
    input  logic [FLOORS-1:0]         req_in,
    input  logic                      door_hold,
    output logic [1:0]                state,
    output logic [FLOORS-1:0]         position,
    output logic [$clog2(FLOORS)-1:0] floor_idx,
    output logic [1:0]                ud_mode,
    output logic                      door_open,
    output logic                      moving,
    output logic [FLOORS-1:0]         pending
);

    localparam int IDX_W = $clog2(FLOORS);

    state_t              state_q, state_d;
    ud_t                 ud_q, ud_d;
    logic [FLOORS-1:0]   pos_q, pending_q, pending_d, clr;
    logic [FLOORS-1:0]   above_mask, below_mask;
    logic [IDX_W-1:0]    idx_q;
    logic                move_up_q;
    logic                kill, up_need, down_need, here_hit, reload;
    logic                move_done, door_done;

    assign kill = rst | ~switch;

    // Floors strictly above / below the one-hot position.
    assign above_mask = ~((pos_q << 1) - FLOORS'(1));
    assign below_mask = pos_q - FLOORS'(1);
    assign up_need    = |(pending_q & above_mask);
    assign down_need  = |(pending_q & below_mask);
    assign here_hit   = |((pending_q | req_in) & pos_q);
    assign reload     = door_hold | (|(req_in & pos_q));

    elevator_timer #(.TICKS(MOVE_TICKS)) u_move_timer (
        .clk  (clk),
        .rst  (kill),
        .clr  (state_q != ST_MOVE),
        .en   (state_q == ST_MOVE),
        .done (move_done)
    );

    elevator_timer #(.TICKS(DOOR_TICKS)) u_door_timer (
        .clk  (clk),
        .rst  (kill),
        .clr  ((state_q != ST_DOOR) | reload),
        .en   (state_q == ST_DOOR),
        .done (door_done)
    );

    always_ff @(posedge clk) begin
        if (kill) state_q <= ST_OFF;
        else      state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:   state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (here_hit)                state_d = ST_DOOR;
                else if (up_need | down_need) state_d = ST_MOVE;
            end
            ST_MOVE:  if (move_done) state_d = ST_PAUSE;
            ST_DOOR:  if (door_done && !reload) state_d = ST_PAUSE;
            default:  state_d = ST_OFF;
        endcase
    end

    // Keep heading the same way while work remains in that direction.
    always_comb begin
        ud_d = ud_q;
        if (pending_q == '0)                     ud_d = UD_IDLE;
        else if (ud_q == UD_UP && up_need)       ud_d = UD_UP;
        else if (ud_q == UD_DOWN && down_need)   ud_d = UD_DOWN;
        else if (up_need)                        ud_d = UD_UP;
        else if (down_need)                      ud_d = UD_DOWN;
    end

    always_comb begin
        clr       = (state_d == ST_DOOR || state_q == ST_DOOR) ? pos_q : '0;
        pending_d = (pending_q | req_in) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            pos_q     <= FLOORS'(1);
            idx_q     <= '0;
            ud_q      <= UD_IDLE;
            pending_q <= '0;
            move_up_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (state_q != ST_OFF) ud_q <= ud_d;
            if (state_q == ST_PAUSE && state_d == ST_MOVE) move_up_q <= (ud_d == UD_UP);
            // Saturating shift; the edge guards only matter if need logic were ever wrong.
            if (state_q == ST_MOVE && move_done) begin
                if (move_up_q && !pos_q[FLOORS-1]) begin
                    pos_q <= pos_q << 1;
                    idx_q <= idx_q + 1'b1;
                end else if (!move_up_q && !pos_q[0]) begin
                    pos_q <= pos_q >> 1;
                    idx_q <= idx_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state     = state_q;
        door_open = (state_q == ST_DOOR);
        moving    = (state_q == ST_MOVE);
        position  = pos_q;
        floor_idx = idx_q;
        ud_mode   = ud_q;
        pending   = pending_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert ($onehot(pos_q));
    end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n: a 4-floor car for the main scenarios and an
// 8-floor car for width scaling.
module tb_elevator_ctrl_n;

    logic       clk = 1'b0;
    logic       rst, switch, door_hold;
    logic [3:0] req_in;
    logic [1:0] state, ud_mode;
    logic [3:0] position, pending;
    logic [1:0] floor_idx;
    logic       door_open, moving;

    logic       rst8, switch8;
    logic [7:0] req8, position8, pending8;
    logic [1:0] state8, ud8;
    logic [2:0] idx8;
    logic       door8, moving8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    elevator_ctrl_n #(.FLOORS(4), .MOVE_TICKS(4), .DOOR_TICKS(3)) dut (
        .clk(clk), .rst(rst), .switch(switch), .req_in(req_in), .door_hold(door_hold),
        .state(state), .position(position), .floor_idx(floor_idx), .ud_mode(ud_mode),
        .door_open(door_open), .moving(moving), .pending(pending)
    );

    elevator_ctrl_n #(.FLOORS(8), .MOVE_TICKS(2), .DOOR_TICKS(3)) dut8 (
        .clk(clk), .rst(rst8), .switch(switch8), .req_in(req8), .door_hold(1'b0),
        .state(state8), .position(position8), .floor_idx(idx8), .ud_mode(ud8),
        .door_open(door8), .moving(moving8), .pending(pending8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and sample 1 time unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; switch = 1'b0; req_in = '0; door_hold = 1'b0;
        rst8 = 1'b1; switch8 = 1'b0; req8 = '0;

        // Reset and start
        step(2);
        check("rst_state", state, 0);
        check("rst_pos", position, 4'b0001);
        check("rst_pending", pending, 0);
        check("rst_door", door_open, 0);
        check("rst_ud", ud_mode, 0);
        rst = 1'b0; switch = 1'b1;
        step(1);
        check("start_pause", state, 1);

        // Simple up trip to floor 2
        req_in = 4'b0100; step(1); req_in = '0;
        check("up_latch", pending, 4'b0100);
        check("up_latch_state", state, 1);
        step(1);
        check("up_moving", moving, 1);
        check("up_ud", ud_mode, 2'b01);
        step(3);
        check("up_still_f0", position, 4'b0001);
        step(1);
        check("up_f1", position, 4'b0010);
        check("up_f1_pause", state, 1);
        step(5);
        check("up_f2", position, 4'b0100);
        check("up_f2_idx", floor_idx, 2);
        step(1);
        check("up_door", door_open, 1);
        check("up_clr", pending, 0);
        step(2);
        check("up_door_c3", door_open, 1);
        step(1);
        check("up_door_closed", door_open, 0);
        check("up_done_state", state, 1);
        check("up_done_ud", ud_mode, 0);

        // Direction persistence
        restart();
        req_in = 4'b1000; step(1); req_in = '0;
        step(1);
        check("dp_moving", moving, 1);
        req_in = 4'b0001; step(1); req_in = '0;
        step(3);
        check("dp_f1", position, 4'b0010);
        check("dp_pend", pending, 4'b1001);
        check("dp_ud_up", ud_mode, 2'b01);
        step(1);
        check("dp_continue_up", moving, 1);
        step(9);
        check("dp_f3", position, 4'b1000);
        step(1);
        check("dp_door_f3", door_open, 1);
        check("dp_pend_f3", pending, 4'b0001);
        check("dp_ud_down", ud_mode, 2'b10);
        step(3);
        check("dp_door_end", state, 1);
        step(1);
        check("dp_move_down", moving, 1);
        req_in = 4'b1000; step(1); req_in = '0;
        check("dp_pend_both", pending, 4'b1001);
        step(3);
        check("dp_f2", position, 4'b0100);
        step(1);
        check("dp_persist_mv", moving, 1);
        check("dp_persist_ud", ud_mode, 2'b10);
        step(9);
        check("dp_f0", position, 4'b0001);
        step(1);
        check("dp_door_f0", door_open, 1);
        check("dp_pend_f0", pending, 4'b1000);
        check("dp_ud_turn", ud_mode, 2'b01);

        // Door hold and re-open
        restart();
        req_in = 4'b0001; step(1); req_in = '0;
        check("dh_door", door_open, 1);
        check("dh_pend", pending, 0);
        step(1);
        door_hold = 1'b1; step(1); door_hold = 1'b0;
        step(2);
        check("dh_c5", door_open, 1);
        step(1);
        check("dh_closed", door_open, 0);
        check("dh_pause", state, 1);
        req_in = 4'b0001; step(1); req_in = '0;
        check("dr_door", door_open, 1);
        step(1);
        req_in = 4'b0001; step(1); req_in = '0;
        check("dr_clr_wins", pending, 0);
        step(2);
        check("dr_c5", door_open, 1);
        step(1);
        check("dr_closed", door_open, 0);

        // Abort mid-MOVE by switch, then by rst
        restart();
        req_in = 4'b1000; step(1); req_in = '0;
        step(12);
        check("ab_mid_pos", position, 4'b0100);
        check("ab_mid_mv", moving, 1);
        switch = 1'b0; req_in = 4'b0010;
        step(1);
        check("ab_sw_state", state, 0);
        check("ab_sw_pos", position, 4'b0001);
        check("ab_sw_idx", floor_idx, 0);
        check("ab_sw_pend", pending, 0);
        check("ab_sw_mv", moving, 0);
        check("ab_sw_ud", ud_mode, 0);
        step(1);
        check("ab_sw_ignore", pending, 0);
        req_in = '0; switch = 1'b1;
        step(1);
        check("ab_sw_resume", state, 1);
        req_in = 4'b1000; step(1); req_in = '0;
        step(12);
        check("ab_rst_mid", position, 4'b0100);
        rst = 1'b1; step(1); rst = 1'b0;
        check("ab_rst_state", state, 0);
        check("ab_rst_pos", position, 4'b0001);
        check("ab_rst_pend", pending, 0);
        check("ab_rst_mv", moving, 0);

        // Width scaling on the 8-floor car
        rst8 = 1'b0; switch8 = 1'b1;
        step(1);
        check("w8_pause", state8, 1);
        req8 = 8'h80; step(1); req8 = '0;
        step(20);
        check("w8_f6", position8, 8'h40);
        check("w8_f6_mv", moving8, 1);
        step(1);
        check("w8_f7", position8, 8'h80);
        check("w8_idx", idx8, 7);
        check("w8_pause_f7", state8, 1);
        step(1);
        check("w8_door", door8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
